// File: rtl/psram_pkg.sv
// Shared types and default widths for the PSRAM controller and its SCK generator.
package psram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } sck_state_t;

  localparam int DIV_W_DEF = 4;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/psram_dly_line.sv
// Fixed-depth shift register with async reset; depth 0 degenerates to a wire.
module psram_dly_line #(
  parameter int DEPTH = 1,
  parameter int W     = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_shift
    logic [W-1:0] shift_q [DEPTH];
    logic [W-1:0] shift_d [DEPTH];

    // Each stage takes the value of the stage before it; stage 0 takes the input.
    always_comb begin
      shift_d[0] = d;
      for (int i = 1; i < DEPTH; i++) begin
        shift_d[i] = shift_q[i-1];
      end
    end

    // Stage registers, cleared only by reset.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int i = 0; i < DEPTH; i++) begin
          shift_q[i] <= '0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          shift_q[i] <= shift_d[i];
        end
      end
    end

    assign q = shift_q[DEPTH-1];
  end

endmodule

// File: rtl/psram_sck_gen.sv
// PSRAM serial-clock generator: programmable low/high phase lengths, optional
// cycle count with done pulse, clean stop that never truncates a high phase,
// and a delayed sample strobe for read-data capture.
module psram_sck_gen
  import psram_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int RD_DLY = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [DIV_W-1:0] lo_div,
  input  logic [DIV_W-1:0] hi_div,
  input  logic [CNT_W-1:0] ncyc,
  output logic             sck,
  output logic             sck_pos,
  output logic             sck_neg,
  output logic             smp_pos,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cyc_left
);

  sck_state_t       state_q, state_d;
  logic             sck_q, sck_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] lo_q, lo_d;
  logic [DIV_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] cyc_left_q, cyc_left_d;
  logic             free_q, free_d;
  logic             done_q, done_d;

  logic lo_hit;
  logic hi_hit;
  logic last_cyc;

  assign lo_hit   = (cnt_q == lo_q);
  assign hi_hit   = (cnt_q == hi_q);
  assign last_cyc = !free_q && (cyc_left_q == CNT_W'(1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a stop in the low phase ends at once, in the high phase it waits for the fall.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop && !sck_q)                  state_d = ST_IDLE;
        else if (sck_neg && (last_cyc || stop)) state_d = ST_IDLE;
        else if (stop)                       state_d = ST_STOP;
      end
      ST_STOP: begin
        if (sck_neg) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state and registers; pause masks both strobes.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    sck_pos = busy && !pause && !sck_q && lo_hit && (state_q == ST_RUN);
    sck_neg = busy && !pause && sck_q && hi_hit;
  end

  // Phase counter, SCK level, cycle count and shadow settings.
  always_comb begin
    sck_d      = sck_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    cyc_left_d = cyc_left_q;
    free_d     = free_q;
    done_d     = 1'b0;
    if (state_q == ST_IDLE) begin
      sck_d = 1'b0;
      cnt_d = '0;
      if (start && !stop) begin
        lo_d       = lo_div;
        hi_d       = hi_div;
        cyc_left_d = ncyc;
        free_d     = (ncyc == '0);
      end
    end else if (state_d == ST_IDLE) begin
      sck_d      = 1'b0;
      cnt_d      = '0;
      cyc_left_d = '0;
      done_d     = 1'b1;
    end else if (!pause) begin
      if (sck_pos) begin
        sck_d = 1'b1;
        cnt_d = '0;
      end else if (sck_neg) begin
        sck_d = 1'b0;
        cnt_d = '0;
        if (!free_q) cyc_left_d = cyc_left_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sck_q      <= 1'b0;
      cnt_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      cyc_left_q <= '0;
      free_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      sck_q      <= sck_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      cyc_left_q <= cyc_left_d;
      free_q     <= free_d;
      done_q     <= done_d;
    end
  end

  assign sck      = sck_q;
  assign done     = done_q;
  assign cyc_left = cyc_left_q;

  psram_dly_line #(
    .DEPTH (RD_DLY),
    .W     (1)
  ) u_smp_dly (
    .clk  (clk),
    .rstn (rstn),
    .d    (sck_pos),
    .q    (smp_pos)
  );

endmodule

// File: tb/tb_psram_sck_gen.sv
// Directed table-driven bench for psram_sck_gen with a two-stage sample delay.
module tb_psram_sck_gen;

  logic        clk;
  logic        rstn;
  logic        start;
  logic        stop;
  logic        pause;
  logic [3:0]  lo_div;
  logic [3:0]  hi_div;
  logic [15:0] ncyc;
  logic        sck;
  logic        sck_pos;
  logic        sck_neg;
  logic        smp_pos;
  logic        busy;
  logic        done;
  logic [15:0] cyc_left;

  int total;
  int bad;

  typedef struct {
    logic        st;
    logic        sp;
    logic        pa;
    logic [3:0]  lo;
    logic [3:0]  hi;
    logic [15:0] nc;
    logic        e_sck;
    logic        e_pos;
    logic        e_neg;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cyc;
  } vec_t;

  vec_t vecs[$];

  psram_sck_gen #(
    .DIV_W  (4),
    .CNT_W  (16),
    .RD_DLY (2)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .lo_div   (lo_div),
    .hi_div   (hi_div),
    .ncyc     (ncyc),
    .sck      (sck),
    .sck_pos  (sck_pos),
    .sck_neg  (sck_neg),
    .smp_pos  (smp_pos),
    .busy     (busy),
    .done     (done),
    .cyc_left (cyc_left)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic st, input logic sp, input logic pa,
                        input logic [3:0] lo, input logic [3:0] hi, input logic [15:0] nc,
                        input logic es, input logic ep, input logic en,
                        input logic eb, input logic ed, input logic [15:0] ec);
    vec_t v;
    v.st = st; v.sp = sp; v.pa = pa; v.lo = lo; v.hi = hi; v.nc = nc;
    v.e_sck = es; v.e_pos = ep; v.e_neg = en; v.e_busy = eb; v.e_done = ed; v.e_cyc = ec;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    start  = v.st;
    stop   = v.sp;
    pause  = v.pa;
    lo_div = v.lo;
    hi_div = v.hi;
    ncyc   = v.nc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  initial begin
    logic hist1;
    logic hist2;
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    lo_div = '0;
    hi_div = '0;
    ncyc   = '0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_sck", {15'd0, sck}, 16'd0);
    checkOutput("rst_busy", {15'd0, busy}, 16'd0);
    checkOutput("rst_done", {15'd0, done}, 16'd0);
    checkOutput("rst_cyc", cyc_left, 16'd0);
    checkOutput("rst_smp", {15'd0, smp_pos}, 16'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // start together with stop in IDLE is ignored
    addVec(1,1,0, 1,1,3,  0,0,0,0,0,0);
    addVec(0,0,0, 1,1,3,  0,0,0,0,0,0);
    // lo=1 hi=1 ncyc=3; a start with new settings mid-burst must be ignored
    addVec(1,0,0, 1,1,3,  0,0,0,1,0,3);
    addVec(0,0,0, 1,1,3,  0,1,0,1,0,3);
    addVec(0,0,0, 1,1,3,  1,0,0,1,0,3);
    addVec(0,0,0, 1,1,3,  1,0,1,1,0,3);
    addVec(0,0,0, 1,1,3,  0,0,0,1,0,2);
    addVec(1,0,0, 0,0,9,  0,1,0,1,0,2);
    addVec(0,0,0, 0,0,9,  1,0,0,1,0,2);
    addVec(0,0,0, 0,0,9,  1,0,1,1,0,2);
    addVec(0,0,0, 0,0,9,  0,0,0,1,0,1);
    addVec(0,0,0, 0,0,9,  0,1,0,1,0,1);
    addVec(0,0,0, 0,0,9,  1,0,0,1,0,1);
    addVec(0,0,0, 0,0,9,  1,0,1,1,0,1);
    addVec(0,0,0, 0,0,9,  0,0,0,0,1,0);
    addVec(0,0,0, 0,0,9,  0,0,0,0,0,0);
    // lo=0 hi=0 ncyc=4: toggle every clk
    addVec(1,0,0, 0,0,4,  0,1,0,1,0,4);
    addVec(0,0,0, 0,0,4,  1,0,1,1,0,4);
    addVec(0,0,0, 0,0,4,  0,1,0,1,0,3);
    addVec(0,0,0, 0,0,4,  1,0,1,1,0,3);
    addVec(0,0,0, 0,0,4,  0,1,0,1,0,2);
    addVec(0,0,0, 0,0,4,  1,0,1,1,0,2);
    addVec(0,0,0, 0,0,4,  0,1,0,1,0,1);
    addVec(0,0,0, 0,0,4,  1,0,1,1,0,1);
    addVec(0,0,0, 0,0,4,  0,0,0,0,1,0);
    addVec(0,0,0, 0,0,4,  0,0,0,0,0,0);
    // lo=2 hi=3 free-run, stop one clk into the high phase
    addVec(1,0,0, 2,3,0,  0,0,0,1,0,0);
    addVec(0,0,0, 2,3,0,  0,0,0,1,0,0);
    addVec(0,0,0, 2,3,0,  0,1,0,1,0,0);
    addVec(0,0,0, 2,3,0,  1,0,0,1,0,0);
    addVec(0,1,0, 2,3,0,  1,0,0,1,0,0);
    addVec(0,0,0, 2,3,0,  1,0,0,1,0,0);
    addVec(0,0,0, 2,3,0,  1,0,1,1,0,0);
    addVec(0,0,0, 2,3,0,  0,0,0,0,1,0);
    addVec(0,0,0, 2,3,0,  0,0,0,0,0,0);
    // stop during the low phase: back to IDLE, no rise
    addVec(1,0,0, 2,3,0,  0,0,0,1,0,0);
    addVec(0,1,0, 2,3,0,  0,0,0,0,1,0);
    addVec(0,0,0, 2,3,0,  0,0,0,0,0,0);
    // lo=3 hi=3 ncyc=2: pause 5 clk in the low phase, then 1 clk on the falling strobe
    addVec(1,0,0, 3,3,2,  0,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  0,0,0,1,0,2);
    for (int i = 0; i < 5; i++) addVec(0,0,1, 3,3,2,  0,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  0,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  0,1,0,1,0,2);
    addVec(0,0,0, 3,3,2,  1,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  1,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  1,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  1,0,1,1,0,2);
    addVec(0,0,1, 3,3,2,  1,0,0,1,0,2);
    addVec(0,0,0, 3,3,2,  0,0,0,1,0,1);
    addVec(0,1,0, 3,3,2,  0,0,0,0,1,0);
    addVec(0,0,0, 3,3,2,  0,0,0,0,0,0);

    hist1 = 1'b0;
    hist2 = 1'b0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("row%0d_sck", i), {15'd0, sck}, {15'd0, vecs[i].e_sck});
      checkOutput($sformatf("row%0d_pos", i), {15'd0, sck_pos}, {15'd0, vecs[i].e_pos});
      checkOutput($sformatf("row%0d_neg", i), {15'd0, sck_neg}, {15'd0, vecs[i].e_neg});
      checkOutput($sformatf("row%0d_busy", i), {15'd0, busy}, {15'd0, vecs[i].e_busy});
      checkOutput($sformatf("row%0d_done", i), {15'd0, done}, {15'd0, vecs[i].e_done});
      checkOutput($sformatf("row%0d_cyc", i), cyc_left, vecs[i].e_cyc);
      checkOutput($sformatf("row%0d_smp", i), {15'd0, smp_pos}, {15'd0, hist2});
      hist2 = hist1;
      hist1 = vecs[i].e_pos;
    end

    // reset in the middle of a 5-cycle burst: no done pulse afterwards
    @(negedge clk);
    start = 1'b1; stop = 1'b0; pause = 1'b0;
    lo_div = 4'd0; hi_div = 4'd0; ncyc = 16'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_sck", {15'd0, sck}, 16'd1);
    checkOutput("mid_cyc", cyc_left, 16'd4);
    rstn = 1'b0;
    #1;
    checkOutput("arst_sck", {15'd0, sck}, 16'd0);
    checkOutput("arst_busy", {15'd0, busy}, 16'd0);
    checkOutput("arst_cyc", cyc_left, 16'd0);
    checkOutput("arst_smp", {15'd0, smp_pos}, 16'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("post_done%0d", k), {15'd0, done}, 16'd0);
      checkOutput($sformatf("post_busy%0d", k), {15'd0, busy}, 16'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/psram_sck_gen.md
Name: psram_sck_gen

Overview:
Parametrised PSRAM serial-clock generator, successor to the fixed 2-bit divider SCK block.
Generates SCK with independent low/high phase lengths and an optional cycle count with a done pulse. Supports clean stop that never truncates a high phase, and a delayed read-sample strobe to absorb SCK/pad round-trip delay.
Sits between the PSRAM controller FSM and the IO pad ring.

Parameters:
DIV_W, 4, width of lo_div/hi_div phase counters (phase length up to 2^DIV_W clk)
CNT_W, 16, width of ncyc cycle counter
RD_DLY, 1, depth in clk of smp_pos delay line; 0 = smp_pos equals sck_pos

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
start  in  1  single-clk request to begin a burst; ignored while busy
stop  in  1  request to end burst early (level or pulse)
pause  in  1  freeze SCK and counters while high
lo_div  in  DIV_W  low phase length minus 1, latched at start
hi_div  in  DIV_W  high phase length minus 1, latched at start
ncyc  in  CNT_W  number of SCK cycles; 0 = free-run until stop; latched at start
sck  out  1  serial clock to pad, registered
sck_pos  out  1  strobe: SCK rises at next clk edge
sck_neg  out  1  strobe: SCK falls at next clk edge
smp_pos  out  1  sck_pos delayed RD_DLY clk, for read-data capture
busy  out  1  burst in progress (RUN or STOP)
done  out  1  one-clk pulse, burst completed
cyc_left  out  CNT_W  remaining SCK cycles (0 in free-run)

Behaviour:
- Reset: sck=0, busy=0, done=0, cyc_left=0, phase cnt=0, state IDLE, delay line cleared.
- States: IDLE, RUN, STOP.
- IDLE: sck=0, cnt=0, no strobes.
  - start && !stop: latch lo_div/hi_div/ncyc into shadow regs; go to RUN.
  - start && stop in the same cycle: start ignored.
- RUN, pause=0:
  - sck=0 && cnt==lo_q: sck<=1, cnt<=0.
  - sck=1 && cnt==hi_q: sck<=0, cnt<=0, cyc_left decrements (non-free-run).
  - Otherwise cnt<=cnt+1.
  - Low phase = lo_q+1 clk; high phase = hi_q+1 clk. Counters DIV_W bits, never wrap past the compare value.
- Strobes, combinational from regs:
  - sck_pos = busy && !pause && sck==0 && cnt==lo_q && state==RUN.
  - sck_neg = busy && !pause && sck==1 && cnt==hi_q.
  - No sck_pos is ever issued in STOP.
- pause=1: sck, cnt, cyc_left held; strobes forced 0; applies in RUN and STOP.
- Burst end: the falling edge that takes cyc_left 1->0 returns to IDLE. On that same edge: sck=0, busy=0, done=1 for one clk.
- stop in RUN:
  - sck=0: go to IDLE next edge; done=1; no partial high phase.
  - sck=1: go to STOP; finish the full high phase; fall; IDLE; done=1.
- stop in STOP or IDLE: no effect.
- start while busy: ignored; shadow regs unchanged.
- Input changes to lo_div/hi_div/ncyc mid-burst: no effect.
- smp_pos: RD_DLY-stage shift of sck_pos; not flushed on stop, so the last sample strobe still emerges. Cleared only by reset.
- Reset mid-burst: immediate return to reset values; no done pulse.

Decomposition:
- Package psram_pkg: state enum (IDLE/RUN/STOP) and default DIV_W/CNT_W constants shared with the controller.
- Sub-module psram_dly_line: parametrised RD_DLY shift register with async reset, used for smp_pos. Reusable for read-data alignment.

Test Plan:
- lo=1, hi=1, ncyc=3, start at edge E0 -> sck rises E2/E6/E10, falls E4/E8/E12; sck_pos high cycles before E2/E6/E10; done=1 and busy=0 at E12; cyc_left 3->2->1->0.
- lo=0, hi=0, ncyc=4 -> sck toggles every clk; 4 rising edges in 8 clk; sck_pos asserted every other cycle.
- lo=2, hi=3, ncyc=0; stop asserted 1 clk into the high phase -> high phase still lasts 4 clk; then sck=0, done pulse. Repeat with stop during low phase -> IDLE next edge, no extra rise.
- pause held 5 clk mid low phase (lo=3, hi=3) -> that low phase lasts 9 clk; sck_pos/sck_neg 0 throughout pause; cyc_left unchanged.
- RD_DLY=2 -> smp_pos equals sck_pos delayed exactly 2 clk, including the strobe issued just before stop.
- rstn low mid-burst (cycle 2 of 5) -> sck=0, busy=0, done never pulses. start with stop same cycle in IDLE -> busy stays 0.
